// File: rtl/tug_battle_ctrl_pkg.sv
// Shared constants for the two-player LED tug battle: state and winner codes,
// display constants and the RESULT-screen decode helpers.
package tug_battle_ctrl_pkg;

  typedef logic [15:0] bar_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_COUNTDOWN = 2'd1;
  localparam logic [1:0] ST_BATTLE    = 2'd2;
  localparam logic [1:0] ST_RESULT    = 2'd3;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [3:0] BLANK = 4'hF;

  localparam bar_t LED_ALL = 16'hFFFF;
  localparam bar_t LED_P1  = 16'hFF00;
  localparam bar_t LED_P2  = 16'h00FF;
  localparam bar_t LED_OFF = 16'h0000;

  // LED bar lit toward the winner's end; both halves for a draw
  function automatic bar_t result_led(input logic [1:0] w);
    case (w)
      WIN_P1:   return LED_P1;
      WIN_P2:   return LED_P2;
      WIN_DRAW: return LED_ALL;
      default:  return LED_OFF;
    endcase
  endfunction

  // Digit shown on the RESULT screen: winning player number, 0 for a draw
  function automatic logic [3:0] result_digit(input logic [1:0] w);
    case (w)
      WIN_P1:  return 4'd1;
      WIN_P2:  return 4'd2;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/tug_battle_ctrl_if.sv
// Game-side bus: control pulses in, display and status out.
interface tug_battle_ctrl_if;
  logic        start;
  logic        p1_fire;
  logic        p2_fire;
  logic        shift_tick;
  logic        sec_tick;
  logic [15:0] led;
  logic [15:0] nums;
  logic [1:0]  state_o;
  logic [1:0]  winner;

  modport master (
    output start, p1_fire, p2_fire, shift_tick, sec_tick,
    input  led, nums, state_o, winner
  );

  modport slave (
    input  start, p1_fire, p2_fire, shift_tick, sec_tick,
    output led, nums, state_o, winner
  );
endinterface

// File: rtl/tug_battle_ctrl_lane.sv
// Shot registers for the 16-LED bar. s1 carries P1 shots toward bit0, s2
// carries P2 shots toward bit15. Hits are flagged from pre-shift values in the
// tick cycle itself so the life counters update on the same edge as the shift.
module battle_lane
  import tug_battle_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic shift_tick,
  input  logic p1_fire,
  input  logic p2_fire,
  output bar_t s1,
  output bar_t s2,
  output logic hit_p1,
  output logic hit_p2
);

  bar_t x1, x2, sh1, sh2, ov, s1_nxt, s2_nxt;

  // P2 shot at bit15 lands on P1; P1 shot at bit0 lands on P2
  assign hit_p1 = shift_tick & s2[15];
  assign hit_p2 = shift_tick & s1[0];

  // Crossing removal, shift, overlap removal, then fire injection
  always_comb begin
    // Adjacent pair s1[i] / s2[i-1] would swap places without ever sharing a bit
    x1  = s1 & {s2[14:0], 1'b0};
    x2  = s2 & {1'b0, s1[15:1]};
    sh1 = (s1 & ~x1) >> 1;
    sh2 = (s2 & ~x2) << 1;
    ov  = sh1 & sh2;
    if (shift_tick) begin
      s1_nxt = sh1 & ~ov;
      s2_nxt = sh2 & ~ov;
    end else begin
      s1_nxt = s1;
      s2_nxt = s2;
    end
    // OR-in: a fire onto an already occupied injection bit is simply lost
    s1_nxt[15] = s1_nxt[15] | p1_fire;
    s2_nxt[0]  = s2_nxt[0]  | p2_fire;
  end

  // Shot state; clear wins over any movement or injection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= LED_OFF;
      s2 <= LED_OFF;
    end else if (clear) begin
      s1 <= LED_OFF;
      s2 <= LED_OFF;
    end else begin
      s1 <= s1_nxt;
      s2 <= s2_nxt;
    end
  end

endmodule

// File: rtl/tug_battle_ctrl.sv
// Game sequencer: IDLE -> COUNTDOWN -> BATTLE -> RESULT. Owns the FSM,
// countdown/result counters, lives and the LED / seven-segment decode.
module tug_battle_ctrl
  import tug_battle_ctrl_pkg::*;
#(
  parameter int LIVES       = 2,
  parameter int CNT_START   = 3,
  parameter int RESULT_SECS = 3
) (
  input logic             clk,
  input logic             rst,
  tug_battle_ctrl_if.slave bus
);

  logic [1:0] state;
  logic [3:0] cnt;
  logic [7:0] rc;
  logic       blink;
  logic [1:0] winner;
  logic [3:0] p1_lives, p2_lives;
  logic [3:0] p1_dec, p2_dec;
  logic       in_battle, game_over, lane_clear;
  bar_t       s1, s2;
  logic       hit_p1, hit_p2;

  assign in_battle  = (state == ST_BATTLE);
  assign p1_dec     = (hit_p1 && p1_lives != 4'd0) ? p1_lives - 4'd1 : p1_lives;
  assign p2_dec     = (hit_p2 && p2_lives != 4'd0) ? p2_lives - 4'd1 : p2_lives;
  assign game_over  = in_battle && (p1_dec == 4'd0 || p2_dec == 4'd0);
  // Shots live only while the battle runs; dropped on abort and on game end
  assign lane_clear = !in_battle || bus.start || game_over;

  battle_lane u_lane (
    .clk        (clk),
    .rst        (rst),
    .clear      (lane_clear),
    .shift_tick (bus.shift_tick & in_battle),
    .p1_fire    (bus.p1_fire & in_battle),
    .p2_fire    (bus.p2_fire & in_battle),
    .s1         (s1),
    .s2         (s2),
    .hit_p1     (hit_p1),
    .hit_p2     (hit_p2)
  );

  // Game FSM; start outranks every other event in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      rc       <= 8'd0;
      blink    <= 1'b0;
      winner   <= WIN_NONE;
      p1_lives <= 4'(LIVES);
      p2_lives <= 4'(LIVES);
    end else if (bus.start) begin
      if (state == ST_IDLE) begin
        state <= ST_COUNTDOWN;
        cnt   <= 4'(CNT_START);
        blink <= 1'b1;
      end else begin
        state <= ST_IDLE;
      end
    end else begin
      case (state)
        ST_COUNTDOWN: if (bus.sec_tick) begin
          blink <= ~blink;
          cnt   <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= ST_BATTLE;
            p1_lives <= 4'(LIVES);
            p2_lives <= 4'(LIVES);
            winner   <= WIN_NONE;
          end
        end
        ST_BATTLE: begin
          p1_lives <= p1_dec;
          p2_lives <= p2_dec;
          if (game_over) begin
            state <= ST_RESULT;
            rc    <= 8'(RESULT_SECS);
            if (p1_dec == 4'd0 && p2_dec == 4'd0) winner <= WIN_DRAW;
            else if (p2_dec == 4'd0)              winner <= WIN_P1;
            else                                  winner <= WIN_P2;
          end
        end
        ST_RESULT: if (bus.sec_tick) begin
          rc <= rc - 8'd1;
          if (rc <= 8'd1) state <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Display decode from registered state only
  always_comb begin
    bus.led     = LED_ALL;
    bus.nums    = 16'h0000;
    bus.state_o = state;
    bus.winner  = winner;
    case (state)
      ST_COUNTDOWN: begin
        bus.led  = blink ? LED_ALL : LED_OFF;
        bus.nums = {BLANK, BLANK, BLANK, cnt};
      end
      ST_BATTLE: begin
        bus.led  = s1 | s2;
        bus.nums = {BLANK, p1_lives, BLANK, p2_lives};
      end
      ST_RESULT: begin
        bus.led  = result_led(winner);
        bus.nums = {BLANK, BLANK, BLANK, result_digit(winner)};
      end
      default: ;
    endcase
  end

endmodule
